br_resolve_queue: RTL and testbench
===================================

// Module: br_resolve_queue
// PURPOSE
//  Collects branch resolutions from two execute-stage branch units and presents at most one per cycle
//  to the branch mask controller as (br_state_o, br_dep_mask_o).
//  Buffers CORRECT resolutions in order, bypasses a WRONG resolution with top priority, and squashes
//  every queued or arriving resolution that depends on the mispredicted branch.
//  Sits between the execute-stage branch units and the branch mask controller / ROB.
// PARAMETERS
//  DEPTH   4   queued CORRECT entries; power of 2, >=2
//  NPORT   2   resolution input ports; fixed at 2
// PORTS
//  clk            in   1                clock, rising edge
//  rst_n          in   1                asynchronous active-low reset
//  res_valid_i    in   2                per-port resolution valid
//  res_wrong_i    in   2                per-port 1=mispredicted, 0=correct
//  res_mask_i     in   2*BR_MASK_W      per-port dep mask; own bit = lowest 0 bit
//  stall_o        in/out: out 1         1 when free entries < 2; units must hold results
//  br_state_o     out  BR_STATE_W       BR_PR_WRONG / BR_PR_CORRECT / idle encoding (all zeros)
//  br_dep_mask_o  out  BR_MASK_W        dep mask of branch in br_state_o
//  empty_o        out  1                queue holds no entries
// BEHAVIOUR
//  - Outputs are registered, 1-cycle latency from input to br_state_o.
//  - Reset, async on rst_n low: queue empty, br_state_o=idle, br_dep_mask_o=0, stall_o=0, empty_o=1.
//    Reset mid-operation discards all entries immediately.
//  - own_bit(m) = one-hot of lowest 0 bit of m. Y depends on X iff Y.mask & own_bit(X.mask) != 0.
//  - Cycle with no WRONG input:
//    - Valid CORRECT inputs enqueue, port 0 before port 1.
//    - Head dequeues to the output regs. Enqueue into a full slot never occurs while stall_o is respected.
//  - Cycle with one WRONG input W:
//    - Next cycle the output is BR_PR_WRONG with W.mask.
//    - The queue head is not dequeued that cycle.
//    - Queued entries and the other port's input that depend on W are dropped.
//      Surviving entries compact, keeping their order.
//    - Independent CORRECT on the other port enqueues.
//  - Two WRONG inputs in the same cycle: the one the other depends on is emitted; the other is dropped.
//    If neither depends on the other, emit port 0 and drop port 1 (cannot occur legally).
//  - WRONG input while a CORRECT is on the output regs: the CORRECT was already emitted last cycle and is unaffected.
//  - Empty queue, no input: output idle, mask 0.
//  - CORRECT input into an empty queue still appears on the output the next cycle (head bypass, no extra cycle).
//  - stall_o is computed from the registered count: (DEPTH - count) < 2.
//  - Overflow when stall_o is ignored:
//    - Excess input is dropped.
//    - Simulation prints an $error.
//  - Pointer wrap: head/tail modulo DEPTH; count width clog2(DEPTH)+1.
// CONFIGURATION
//  BR_RESOLVE_STATS_EN defined: adds outputs stat_correct_o, stat_wrong_o, stat_squash_o, 32 bits each.
//    - Each counts emitted CORRECT, emitted WRONG, and dropped dependent entries/inputs.
//    - Counters wrap at 2^32 and clear on reset.
//  BR_RESOLVE_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream with 3 entries queued -> empty_o=1, br_state_o=idle, mask=0 immediately.
//  2 Port0 CORRECT mask 5'b00001 plus port1 CORRECT mask 5'b00011 in one cycle
//    -> CORRECT 00001 in cycle+1, CORRECT 00011 in cycle+2, then idle.
//  3 Queue holds CORRECT 00011 and 00111; WRONG mask 00001 arrives
//    -> next cycle WRONG 00001; both entries squashed; empty_o=1; stat_squash_o+=2.
//  4 Simultaneous WRONG port0 mask 00011 and WRONG port1 mask 00001
//    -> only WRONG 00001 emitted; port0 dropped.
//  5 Fill DEPTH=4 with CORRECT, no drain stall -> stall_o=1 at count 3; inputs held -> no loss, in-order drain.
//  6 WRONG 00001 with independent CORRECT 00000 queued
//    -> WRONG emitted first, CORRECT 00000 emitted the following cycle.

Source files
------------

// File: rtl/br_resolve_queue_if.sv
// Resolution bus between the execute-stage branch units (master) and
// br_resolve_queue (slave). One valid/wrong/mask lane per branch unit,
// with a shared stall back to the units.
interface br_resolve_queue_if #(
  parameter int NPORT     = 2,
  parameter int BR_MASK_W = 5
);
  logic [NPORT-1:0]           res_valid;
  logic [NPORT-1:0]           res_wrong;
  logic [NPORT*BR_MASK_W-1:0] res_mask;
  logic                       stall;

  modport master (output res_valid, output res_wrong, output res_mask, input stall);
  modport slave  (input res_valid, input res_wrong, input res_mask, output stall);
endinterface

// File: rtl/br_resolve_queue.sv
// br_resolve_queue: merges branch resolutions from two branch units into one
// resolution per cycle for the branch mask controller. CORRECT resolutions are
// queued in order (with head bypass); a WRONG resolution goes out first and
// squashes every queued or arriving resolution that depends on it.
// Optional feature macro: BR_RESOLVE_STATS_EN adds 32-bit counters
// o_stat_correct, o_stat_wrong and o_stat_squash.
module br_resolve_queue #(
  parameter int DEPTH      = 4,
  parameter int NPORT      = 2,
  parameter int BR_MASK_W  = 5,
  parameter int BR_STATE_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  br_resolve_queue_if.slave     i_res,
  output logic [BR_STATE_W-1:0] o_br_state,
  output logic [BR_MASK_W-1:0]  o_br_dep_mask,
  output logic                  o_empty
`ifdef BR_RESOLVE_STATS_EN
  ,
  output logic [31:0]           o_stat_correct,
  output logic [31:0]           o_stat_wrong,
  output logic [31:0]           o_stat_squash
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [BR_STATE_W-1:0] BR_PR_IDLE    = BR_STATE_W'(2'd0);
  localparam logic [BR_STATE_W-1:0] BR_PR_CORRECT = BR_STATE_W'(2'd1);
  localparam logic [BR_STATE_W-1:0] BR_PR_WRONG   = BR_STATE_W'(2'd2);

  // One-hot of the lowest zero bit: the branch's own tag within its mask.
  function automatic logic [BR_MASK_W-1:0] own_bit(input logic [BR_MASK_W-1:0] m);
    return ~m & (m + BR_MASK_W'(1'b1));
  endfunction

  // y depends on x when y's mask carries x's own tag.
  function automatic logic depends_on(input logic [BR_MASK_W-1:0] y,
                                      input logic [BR_MASK_W-1:0] x);
    return |(y & own_bit(x));
  endfunction

  logic [BR_MASK_W-1:0]  r_q [DEPTH];
  logic [PW-1:0]         r_head;
  logic [CW-1:0]         r_count;
  logic [BR_STATE_W-1:0] r_state;
  logic [BR_MASK_W-1:0]  r_mask;
  logic                  r_empty;
  logic                  r_stall;

  logic [BR_MASK_W-1:0]  w_in_mask [NPORT];
  logic [NPORT-1:0]      w_wr;
  logic [NPORT-1:0]      w_cr;
  logic                  w_any_wrong;
  logic                  w_sel;
  logic                  w_oth;
  logic [BR_MASK_W-1:0]  w_wmask;
  logic                  w_oth_dep;

  logic [BR_MASK_W-1:0]  w_ord [DEPTH];
  logic [DEPTH-1:0]      w_live;
  logic [DEPTH-1:0]      w_sq_vec;

  logic [BR_MASK_W-1:0]  w_q_nxt [DEPTH];
  logic [PW-1:0]         w_head_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [BR_STATE_W-1:0] w_state_nxt;
  logic [BR_MASK_W-1:0]  w_mask_nxt;
  logic [PW-1:0]         w_widx;
  logic                  w_emit;
  logic                  w_ovf;

  genvar gp;
  for (gp = 0; gp < NPORT; gp++) begin : g_unpack
    assign w_in_mask[gp] = i_res.res_mask[gp*BR_MASK_W +: BR_MASK_W];
  end

  assign w_wr        = i_res.res_valid & i_res.res_wrong;
  assign w_cr        = i_res.res_valid & ~i_res.res_wrong;
  assign w_any_wrong = |w_wr;
  // Port 1 wins only as the sole WRONG or when port 0 depends on it.
  assign w_sel       = w_wr[1] & (~w_wr[0] | depends_on(w_in_mask[0], w_in_mask[1]));
  assign w_oth       = ~w_sel;
  assign w_wmask     = w_in_mask[w_sel];
  assign w_oth_dep   = i_res.res_valid[w_oth] & depends_on(w_in_mask[w_oth], w_wmask);

  // Age-ordered view of the queue and which live entries the WRONG squashes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ord[i]    = r_q[r_head + PW'(i)];
      w_live[i]   = CW'(i) < r_count;
      w_sq_vec[i] = w_live[i] & depends_on(w_ord[i], w_wmask);
    end
  end

  // Next queue contents and next output: WRONG bypass/compaction or in-order CORRECT flow.
  always_comb begin
    w_q_nxt     = r_q;
    w_head_nxt  = r_head;
    w_cnt_nxt   = r_count;
    w_state_nxt = BR_PR_IDLE;
    w_mask_nxt  = '0;
    w_widx      = '0;
    w_emit      = 1'b0;
    w_ovf       = 1'b0;
    if (w_any_wrong) begin
      w_state_nxt = BR_PR_WRONG;
      w_mask_nxt  = w_wmask;
      w_cnt_nxt   = '0;
      // Survivors are rewritten contiguously from the current head, oldest first.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_live[i] && !w_sq_vec[i]) begin
          w_widx          = r_head + w_cnt_nxt[PW-1:0];
          w_q_nxt[w_widx] = w_ord[i];
          w_cnt_nxt       = w_cnt_nxt + CW'(1'b1);
        end else begin
          w_cnt_nxt = w_cnt_nxt;
        end
      end
      if (w_cr[w_oth] && !w_oth_dep) begin
        if (w_cnt_nxt < CW'(DEPTH)) begin
          w_widx          = r_head + w_cnt_nxt[PW-1:0];
          w_q_nxt[w_widx] = w_in_mask[w_oth];
          w_cnt_nxt       = w_cnt_nxt + CW'(1'b1);
        end else begin
          w_ovf = 1'b1;
        end
      end else begin
        w_ovf = 1'b0;
      end
    end else begin
      if (r_count != '0) begin
        w_state_nxt = BR_PR_CORRECT;
        w_mask_nxt  = r_q[r_head];
        w_emit      = 1'b1;
        w_head_nxt  = r_head + PW'(1'b1);
        w_cnt_nxt   = r_count - CW'(1'b1);
      end else begin
        w_emit = 1'b0;
      end
      // Port 0 before port 1; the first one bypasses an empty queue.
      for (int p = 0; p < NPORT; p++) begin
        if (w_cr[p] && !w_emit) begin
          w_state_nxt = BR_PR_CORRECT;
          w_mask_nxt  = w_in_mask[p];
          w_emit      = 1'b1;
        end else if (w_cr[p] && (w_cnt_nxt < CW'(DEPTH))) begin
          w_widx          = w_head_nxt + w_cnt_nxt[PW-1:0];
          w_q_nxt[w_widx] = w_in_mask[p];
          w_cnt_nxt       = w_cnt_nxt + CW'(1'b1);
        end else if (w_cr[p]) begin
          w_ovf = 1'b1;
        end else begin
          w_ovf = w_ovf;
        end
      end
    end
  end

  // Queue state and registered outputs; async reset discards everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_head  <= '0;
      r_count <= '0;
      r_state <= BR_PR_IDLE;
      r_mask  <= '0;
      r_empty <= 1'b1;
      r_stall <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_head  <= w_head_nxt;
      r_count <= w_cnt_nxt;
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_stall <= (CW'(DEPTH) - w_cnt_nxt) < CW'(2'd2);
    end
  end

  // Report resolutions lost because the branch units ignored stall.
  always_ff @(posedge clk) begin
    if (rst_n && w_ovf) begin
      $error("br_resolve_queue: overflow, resolution dropped");
    end
  end

`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] r_stat_correct;
  logic [31:0] r_stat_wrong;
  logic [31:0] r_stat_squash;

  // Emitted CORRECT/WRONG and squashed dependents; counters wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_correct <= 32'd0;
      r_stat_wrong   <= 32'd0;
      r_stat_squash  <= 32'd0;
    end else begin
      r_stat_correct <= r_stat_correct + ((w_state_nxt == BR_PR_CORRECT) ? 32'd1 : 32'd0);
      r_stat_wrong   <= r_stat_wrong + (w_any_wrong ? 32'd1 : 32'd0);
      r_stat_squash  <= r_stat_squash +
                        (w_any_wrong ? (32'($countones(w_sq_vec)) + 32'(w_oth_dep)) : 32'd0);
    end
  end

  assign o_stat_correct = r_stat_correct;
  assign o_stat_wrong   = r_stat_wrong;
  assign o_stat_squash  = r_stat_squash;
`endif

  assign o_br_state    = r_state;
  assign o_br_dep_mask = r_mask;
  assign o_empty       = r_empty;
  assign i_res.stall   = r_stall;

endmodule

// File: tb/tb_br_resolve_queue.sv
// Bench for br_resolve_queue: directed scenarios plus random traffic. Each
// driven cycle runs a queue-of-masks reference model and pushes the expected
// registered output; a monitor pops and compares one entry per clock.
`timescale 1ns/1ps
module tb_br_resolve_queue;
  localparam int DEPTH = 4;
  localparam int MW    = 5;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CORR  = 2'd1;
  localparam logic [1:0] ST_WRONG = 2'd2;

  typedef struct packed {
    logic [1:0]    st;
    logic [MW-1:0] m;
    logic          e;
    logic          s;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  br_resolve_queue_if #(.NPORT(2), .BR_MASK_W(MW)) bus ();
  logic [1:0]    br_state;
  logic [MW-1:0] br_mask;
  logic          empty;
`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] st_c, st_w, st_s;
`endif

  br_resolve_queue #(.DEPTH(DEPTH), .NPORT(2), .BR_MASK_W(MW), .BR_STATE_W(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_res(bus),
    .o_br_state(br_state),
    .o_br_dep_mask(br_mask),
    .o_empty(empty)
`ifdef BR_RESOLVE_STATS_EN
    ,
    .o_stat_correct(st_c),
    .o_stat_wrong(st_w),
    .o_stat_squash(st_s)
`endif
  );

  exp_t          exp_q[$];
  logic [MW-1:0] mq[$];
  int total = 0;
  int bad   = 0;
  int n_correct = 0, n_wrong = 0, n_squash = 0;

  // Own tag: lowest clear bit of the mask.
  function automatic logic [MW-1:0] own(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    r = '0;
    for (int b = 0; b < MW; b++) begin
      if (m[b] == 1'b0) begin
        r[b] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic dep(input logic [MW-1:0] y, input logic [MW-1:0] x);
    return (y & own(x)) != '0;
  endfunction

  function automatic logic mstall();
    return (DEPTH - mq.size()) < 2;
  endfunction

  task automatic model_step(input logic [1:0] v, input logic [1:0] w,
                            input logic [MW-1:0] m0, input logic [MW-1:0] m1);
    exp_t          e;
    logic [MW-1:0] m[2];
    logic [MW-1:0] kept[$];
    int            win;
    m[0] = m0;
    m[1] = m1;
    e.st = ST_IDLE;
    e.m  = '0;
    if ((v[0] && w[0]) || (v[1] && w[1])) begin
      if (v[0] && w[0] && v[1] && w[1]) win = dep(m0, m1) ? 1 : 0;
      else win = (v[0] && w[0]) ? 0 : 1;
      e.st = ST_WRONG;
      e.m  = m[win];
      n_wrong++;
      foreach (mq[i]) begin
        if (dep(mq[i], m[win])) n_squash++;
        else kept.push_back(mq[i]);
      end
      if (v[1-win]) begin
        if (dep(m[1-win], m[win])) n_squash++;
        else if (!w[1-win]) kept.push_back(m[1-win]);
      end
      mq = kept;
    end else begin
      for (int p = 0; p < 2; p++) if (v[p]) mq.push_back(m[p]);
      if (mq.size() > 0) begin
        e.st = ST_CORR;
        e.m  = mq.pop_front();
        n_correct++;
      end
    end
    e.e = (mq.size() == 0);
    e.s = mstall();
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [1:0] v, input logic [1:0] w,
                     input logic [MW-1:0] m0, input logic [MW-1:0] m1);
    @(negedge clk);
    bus.res_valid = v;
    bus.res_wrong = w;
    bus.res_mask  = {m1, m0};
    model_step(v, w, m0, m1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(2'b00, 2'b00, 5'b00000, 5'b00000);
  endtask

  task automatic check_reset(input string name);
    total++;
    if ({br_state, br_mask, empty, bus.stall} !== {ST_IDLE, 5'b00000, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL %s: got st=%0d m=%b empty=%b stall=%b want st=0 m=00000 empty=1 stall=0",
               name, br_state, br_mask, empty, bus.stall);
    end
  endtask

  // Monitor: one expected registered output per clock edge.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {br_state, br_mask, empty, bus.stall};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL out@%0t: got st=%0d m=%b empty=%b stall=%b want st=%0d m=%b empty=%b stall=%b",
                   $time, a.st, a.m, a.e, a.s, e.st, e.m, e.e, e.s);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    v, w;
    logic [MW-1:0] m0, m1;
    int            k;
    bus.res_valid = 2'b00;
    bus.res_wrong = 2'b00;
    bus.res_mask  = '0;
    #1 rst_n = 1'b0;
    #1 check_reset("reset_initial");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Two CORRECTs in one cycle: port 0 bypasses, port 1 follows.
    cyc(2'b11, 2'b00, 5'b00001, 5'b00011);
    idle(2);

    // Queue holds 00011, 00111; WRONG 00001 squashes both.
    cyc(2'b11, 2'b00, 5'b00000, 5'b00000);
    cyc(2'b11, 2'b00, 5'b00011, 5'b00111);
    cyc(2'b01, 2'b01, 5'b00001, 5'b00000);
    idle(1);

    // Two WRONGs: port 0 depends on port 1, so port 1 is emitted.
    cyc(2'b11, 2'b11, 5'b00011, 5'b00001);
    idle(1);

    // WRONG with an independent CORRECT 00000 queued.
    cyc(2'b11, 2'b00, 5'b00000, 5'b00000);
    cyc(2'b01, 2'b01, 5'b00001, 5'b00000);
    idle(2);

    // Fill until stall, hold inputs while stalled, then drain in order.
    for (int i = 0; i < 8; i++) begin
      if (!mstall()) cyc(2'b11, 2'b00, 5'($urandom), 5'($urandom));
      else idle(1);
    end
    idle(DEPTH + 1);

    // Reset mid-stream with three entries queued.
    cyc(2'b11, 2'b00, 5'b00010, 5'b00100);
    cyc(2'b11, 2'b00, 5'b01000, 5'b10000);
    cyc(2'b11, 2'b00, 5'b00110, 5'b01100);
    @(negedge clk);
    bus.res_valid = 2'b00;
    rst_n = 1'b0;
    #1 check_reset("reset_midstream");
    mq.delete();
    n_correct = 0;
    n_wrong   = 0;
    n_squash  = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic honouring stall.
    for (int i = 0; i < 400; i++) begin
      if (mstall()) begin
        idle(1);
      end else begin
        v    = 2'($urandom_range(0, 3));
        w[0] = ($urandom_range(0, 5) == 0);
        w[1] = ($urandom_range(0, 5) == 0);
        m0   = 5'($urandom);
        m1   = 5'($urandom);
        cyc(v, w, m0, m1);
      end
    end
    idle(DEPTH + 2);

    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end

`ifdef BR_RESOLVE_STATS_EN
    total++;
    if ({st_c, st_w, st_s} !== {32'(n_correct), 32'(n_wrong), 32'(n_squash)}) begin
      bad++;
      $display("FAIL stats: got c=%0d w=%0d s=%0d want c=%0d w=%0d s=%0d",
               st_c, st_w, st_s, n_correct, n_wrong, n_squash);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
